// File: rtl/mem_reader_if.sv
// Memory read port and byte-stream output shared by mem_reader and its peers.
// The master modport is the reader side.
interface mem_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr, mem_rd, out_data, out_valid,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd, out_data, out_valid,
    output mem_data, out_ready
  );
endinterface

// File: rtl/mem_reader.sv
// Streams length bytes from data memory starting at base_addr,
// one byte per valid/ready handshake, after a rising edge on start.
module mem_reader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  mem_reader_if.master      bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    HOLD,
    FIN
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              start_q;
  logic              start_qq;
  logic              rise;
  logic              hs;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] data;

  assign rise = start_q & ~start_qq;
  assign hs   = (state == HOLD) & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (rise) state_nx = (length == '0) ? FIN : READ;
      end
      READ:    state_nx = CAPTURE;
      CAPTURE: state_nx = HOLD;
      HOLD: begin
        if (hs) state_nx = (cnt == ADDR_W'(1)) ? FIN : READ;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // start is double-registered; a rise is acted on only in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      start_qq <= 1'b0;
      addr     <= '0;
      cnt      <= '0;
      data     <= '0;
    end else begin
      start_q  <= start;
      start_qq <= start_q;
      if ((state == IDLE) && rise && (length != '0)) begin
        addr <= base_addr;
        cnt  <= length;
      end
      if (state == CAPTURE) data <= bus.mem_data;
      if (hs) begin
        addr <= addr + ADDR_W'(1);
        cnt  <= cnt - ADDR_W'(1);
      end
    end
  end

  assign bus.mem_addr  = addr;
  assign bus.mem_rd    = (state == READ);
  assign bus.out_data  = data;
  assign bus.out_valid = (state == HOLD);
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);

endmodule

// File: tb/tb_mem_reader.sv
// Scoreboard bench for mem_reader: directed transfers against a
// registered-read memory model; a negedge monitor checks the stream.
module tb_mem_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;

  mem_reader_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_reader #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];

  always @(posedge clk)
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

  int          checks = 0;
  int          failures = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          valid_cnt = 0;
  logic [7:0]  exp_q [$];
  logic [15:0] addr_log [$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_data", {24'd0, bus.out_data}, {24'd0, prev_data});
      end
      if (bus.mem_rd) begin
        rd_cnt++;
        addr_log.push_back(bus.mem_addr);
      end
      if (done) done_cnt++;
      if (bus.out_valid) valid_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h required=none",
                   bus.out_data);
        end else begin
          chk("byte", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // which: 0 = out_valid high, 1 = done high, 2 = out_valid low
  task automatic wait_for(input int which, input int maxc,
                          input string name, output int k);
    bit hit;
    hit = 1'b0;
    k = 0;
    while (!hit && k < maxc) begin
      @(posedge clk);
      #1;
      k++;
      if (which == 0 && bus.out_valid) hit = 1'b1;
      if (which == 1 && done) hit = 1'b1;
      if (which == 2 && !bus.out_valid) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=%0d required<%0d", name, k, maxc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [15:0] b, input logic [15:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
  endtask

  int k;
  int rd0;
  int dn0;
  int vl0;
  int rds;
  logic [15:0] ea [4];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = 16'h0;
    length = 16'h0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'hA1; mem[16'h0011] = 8'hB2; mem[16'h0012] = 8'hC3;
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;
    mem[16'h0000] = 8'h33; mem[16'h0001] = 8'h44;
    mem[16'h0020] = 8'hD1; mem[16'h0021] = 8'hD2; mem[16'h0022] = 8'hD3;
    mem[16'h0030] = 8'h5C; mem[16'h0031] = 8'h6D;
    mem[16'h0040] = 8'h71; mem[16'h0041] = 8'h72;
    mem[16'h0042] = 8'h73; mem[16'h0043] = 8'h74;
    #1;
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // basic 3-byte transfer, inputs disturbed mid-transfer
    rd0 = rd_cnt; dn0 = done_cnt;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    bus.out_ready = 1'b1;
    kick(16'h0010, 16'd3);
    wait_for(0, 20, "first_valid", k);
    // counts the edge that samples the rise as 1
    chk("first_valid_lat", k, 4);
    base_addr = 16'h0099;
    length = 16'd7;
    wait_for(1, 40, "t1_done", k);
    cycles(1);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_done_once", done_cnt - dn0, 1);
    chk("t1_reads", rd_cnt - rd0, 3);
    chk("t1_queue_empty", exp_q.size(), 0);
    start = 1'b0;
    cycles(3);

    // address wrap
    rd0 = rd_cnt; dn0 = done_cnt;
    addr_log.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    kick(16'hFFFE, 16'd4);
    wait_for(1, 40, "t2_done", k);
    cycles(1);
    start = 1'b0;
    ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    chk("t2_reads", addr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < addr_log.size())
        chk("t2_addr", {16'd0, addr_log[i]}, {16'd0, ea[i]});
    chk("t2_queue_empty", exp_q.size(), 0);
    chk("t2_done_once", done_cnt - dn0, 1);
    cycles(3);

    // zero length
    rd0 = rd_cnt; dn0 = done_cnt; vl0 = valid_cnt;
    kick(16'h0010, 16'd0);
    wait_for(1, 10, "t3_done", k);
    chk("t3_done_lat", k, 2);
    cycles(2);
    start = 1'b0;
    chk("t3_no_read", rd_cnt - rd0, 0);
    chk("t3_no_valid", valid_cnt - vl0, 0);
    chk("t3_done_once", done_cnt - dn0, 1);
    cycles(3);

    // consumer stall on the 2nd byte
    rd0 = rd_cnt; dn0 = done_cnt;
    exp_q.push_back(8'hD1); exp_q.push_back(8'hD2); exp_q.push_back(8'hD3);
    kick(16'h0020, 16'd3);
    wait_for(0, 20, "t4_b1", k);
    wait_for(2, 5, "t4_b1_gone", k);
    bus.out_ready = 1'b0;
    wait_for(0, 10, "t4_b2", k);
    rds = rd_cnt;
    cycles(5);
    chk("t4_no_extra_rd", rd_cnt - rds, 0);
    chk("t4_b2_pending", exp_q.size(), 2);
    bus.out_ready = 1'b1;
    wait_for(1, 30, "t4_done", k);
    cycles(1);
    start = 1'b0;
    chk("t4_reads", rd_cnt - rd0, 3);
    chk("t4_queue_empty", exp_q.size(), 0);
    chk("t4_done_once", done_cnt - dn0, 1);
    cycles(3);

    // start held high across a transfer
    rd0 = rd_cnt; dn0 = done_cnt;
    exp_q.push_back(8'h5C); exp_q.push_back(8'h6D);
    kick(16'h0030, 16'd2);
    cycles(50);
    chk("t5_one_done", done_cnt - dn0, 1);
    chk("t5_reads", rd_cnt - rd0, 2);
    chk("t5_queue_empty", exp_q.size(), 0);
    start = 1'b0;
    cycles(4);
    chk("t5_no_requeue", done_cnt - dn0, 1);
    exp_q.push_back(8'h5C); exp_q.push_back(8'h6D);
    kick(16'h0030, 16'd2);
    wait_for(1, 30, "t5_second", k);
    cycles(1);
    start = 1'b0;
    chk("t5_two_done", done_cnt - dn0, 2);
    chk("t5_queue_empty2", exp_q.size(), 0);
    cycles(3);

    // reset in HOLD of byte 2 of 4
    dn0 = done_cnt;
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    exp_q.push_back(8'h73); exp_q.push_back(8'h74);
    kick(16'h0040, 16'd4);
    wait_for(0, 20, "t6_b1", k);
    bus.out_ready = 1'b1;
    cycles(1);
    bus.out_ready = 1'b0;
    wait_for(0, 10, "t6_b2", k);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_rst_data", {24'd0, bus.out_data}, 32'd0);
    chk("t6_rst_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("t6_rst_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    chk("t6_pending", exp_q.size(), 3);
    exp_q.delete();
    start = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    chk("t6_no_done", done_cnt - dn0, 0);
    chk("t6_idle", {31'd0, busy}, 32'd0);
    rd0 = rd_cnt;
    exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    exp_q.push_back(8'h73); exp_q.push_back(8'h74);
    bus.out_ready = 1'b1;
    kick(16'h0040, 16'd4);
    wait_for(1, 40, "t6_fresh", k);
    cycles(1);
    start = 1'b0;
    chk("t6_fresh_reads", rd_cnt - rd0, 4);
    chk("t6_fresh_queue", exp_q.size(), 0);
    chk("t6_fresh_done", done_cnt - dn0, 1);
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
